serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub_pkg.sv | 19 +
 rtl/serial_add_sub_full_adder.sv | 17 +
 rtl/serial_add_sub.sv | 113 +++++++++++
 tb/tb_serial_add_sub.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   - ST_IDLE / ST_RUN / ST_DONE : FSM state encodings
//   - state_t                    : 2-bit state type
//   - counter_width()            : bit-counter width for a given operand width
package serial_add_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // The counter only has to reach width-1, so clog2(width) bits suffice.
    // It is never narrower than one bit.
    function automatic int counter_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder cell: the bit-slice of the serial adder.
//   A_i, B_i : operand bits
//   C_i      : carry in
//   S_o      : sum bit
//   C_o      : carry out
module full_adder (
    input  logic A_i,
    input  logic B_i,
    input  logic C_i,
    output logic S_o,
    output logic C_o
);

    assign S_o = A_i ^ B_i ^ C_i;
    assign C_o = (A_i & B_i) | (C_i & (A_i ^ B_i));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor. It processes one bit per clock,
// LSB first, through a single full_adder cell and a carry flop.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   Start_i        : request, sampled only when not busy
//   Sub_i          : 0 = A+B, 1 = A-B (captured with Start_i)
//   A_i, B_i       : operands (captured with Start_i)
//   Busy_o         : high while an operation is in progress
//   Done_o         : one-cycle pulse when S_o/C_o/V_o are updated
//   S_o, C_o, V_o  : result, carry-out (subtract: 1 = no borrow), overflow
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             Start_i,
    input  logic             Sub_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o,
    output logic             V_o
);

    localparam int               CNT_W = counter_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;   // B already conditionally inverted
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] r_next;

    full_adder u_fa (
        .A_i (a_sh[0]),
        .B_i (b_sh[0]),
        .C_i (carry),
        .S_o (fa_s),
        .C_o (fa_c)
    );

    // The sum bit enters at the MSB, so after WIDTH shifts the LSB of the
    // result has reached bit 0.
    assign r_next = {fa_s, r_sh[WIDTH-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Busy_o <= 1'b0;
            Done_o <= 1'b0;
            S_o    <= '0;
            C_o    <= 1'b0;
            V_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    Done_o <= 1'b0;
                    if (Start_i) begin
                        // Subtraction is A + ~B + 1: invert B here and
                        // preload the carry with the +1.
                        a_sh   <= A_i;
                        b_sh   <= B_i ^ {WIDTH{Sub_i}};
                        carry  <= Sub_i;
                        cnt    <= '0;
                        Busy_o <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // On the MSB step, the carry flop holds the carry
                        // into the MSB. Overflow is that carry XOR the
                        // carry out of the MSB.
                        S_o    <= r_next;
                        C_o    <= fa_c;
                        V_o    <= carry ^ fa_c;
                        Busy_o <= 1'b0;
                        Done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end

                default: begin
                    Busy_o <= 1'b0;
                    Done_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         Start_i;
    logic         Sub_i;
    logic [W-1:0] A_i;
    logic [W-1:0] B_i;
    logic         Busy_o;
    logic         Done_o;
    logic [W-1:0] S_o;
    logic         C_o;
    logic         V_o;

    int checks = 0;
    int errors = 0;

    // Value S_o is expected to hold from the previous completion.
    logic [W-1:0] last_s = '0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .Start_i (Start_i),
        .Sub_i   (Sub_i),
        .A_i     (A_i),
        .B_i     (B_i),
        .Busy_o  (Busy_o),
        .Done_o  (Done_o),
        .S_o     (S_o),
        .C_o     (C_o),
        .V_o     (V_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, output logic [W-1:0] s,
                                  output logic c, output logic v);
        logic [W:0] full;
        int         sa, sb, st;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            st   = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b};
            st   = sa + sb;
        end
        s = full[W-1:0];
        c = full[W];
        v = (st > 127) || (st < -128);
    endfunction

    // Issue one request at the current negedge. Return at the negedge where
    // Done_o is seen (or when the cycle budget runs out). lat counts clock
    // edges after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, output int lat, output int busy_n);
        Start_i = 1'b1;
        A_i     = a;
        B_i     = b;
        Sub_i   = sub;
        @(posedge clk_i);
        @(negedge clk_i);
        Start_i = 1'b0;
        A_i     = W'($urandom);
        B_i     = W'($urandom);
        Sub_i   = 1'($urandom);
        lat     = 0;
        busy_n  = 0;
        while (!Done_o && lat < 40) begin
            if (Busy_o) busy_n++;
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({Busy_o, Done_o, S_o, C_o, V_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b s=%h c=%b v=%b want all 0",
                     Busy_o, Done_o, S_o, C_o, V_o);
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic sub,
                            input logic [W-1:0] es, input logic ec, input logic ev);
        int lat, busy_n;
        do_op(a, b, sub, lat, busy_n);
        checks++;
        if ({S_o, C_o, V_o} !== {es, ec, ev}) begin
            errors++;
            $display("FAIL %s result got s=%h c=%b v=%b want s=%h c=%b v=%b",
                     name, S_o, C_o, V_o, es, ec, ev);
        end
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, W);
        end
        checks++;
        if (busy_n !== W) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, busy_n, W);
        end
        last_s = es;
    endtask

    task automatic test_add();
        check_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        @(negedge clk_i);
        checks++;
        if (Done_o !== 1'b0) begin
            errors++;
            $display("FAIL add_done_pulse got done=%b want 0", Done_o);
        end
    endtask

    task automatic test_back_to_back();
        check_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        // Start issued in the DONE cycle itself: there is no idle gap.
        check_op("b2b_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk_i);
    endtask

    task automatic test_sub();
        check_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        @(negedge clk_i);
        check_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        @(negedge clk_i);
    endtask

    task automatic test_busy_protect();
        int           done_cnt;
        logic [W-1:0] s_at;
        done_cnt = 0;
        s_at     = '0;
        Start_i = 1'b1; A_i = 8'h10; B_i = 8'h20; Sub_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        Start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                Start_i = 1'b1; A_i = 8'hAA; B_i = 8'h55; Sub_i = 1'b1;
            end
            if (i == 3) Start_i = 1'b0;
            if (Done_o) begin
                done_cnt++;
                s_at = S_o;
            end else if (done_cnt == 0) begin
                checks++;
                if (S_o !== last_s) begin
                    errors++;
                    $display("FAIL busy_hold_s cycle %0d got %h want %h", i, S_o, last_s);
                end
            end
            @(negedge clk_i);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL busy_done_count got %0d want 1", done_cnt);
        end
        checks++;
        if (s_at !== 8'h30) begin
            errors++;
            $display("FAIL busy_result got %h want 30", s_at);
        end
        last_s = 8'h30;
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat, busy_n;
        seen = 0;
        Start_i = 1'b1; A_i = 8'h33; B_i = 8'h11; Sub_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        Start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({Busy_o, Done_o, S_o, C_o, V_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b s=%h c=%b v=%b want all 0",
                     Busy_o, Done_o, S_o, C_o, V_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            if (Done_o || Busy_o) seen++;
            @(negedge clk_i);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_discard got %0d active cycles want 0", seen);
        end
        do_op(8'h01, 8'h01, 1'b0, lat, busy_n);
        checks++;
        if ({S_o, lat} !== {8'h02, W}) begin
            errors++;
            $display("FAIL after_reset_add got s=%h lat=%0d want s=02 lat=%0d", S_o, lat, W);
        end
        @(negedge clk_i);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, es;
        logic         sub, ec, ev, b2b;
        int           lat, busy_n;
        for (int n = 0; n < 1000; n++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            model(a, b, sub, es, ec, ev);
            do_op(a, b, sub, lat, busy_n);
            checks++;
            if ({S_o, C_o, V_o} !== {es, ec, ev}) begin
                errors++;
                $display("FAIL rand_%0d a=%h b=%h sub=%b got s=%h c=%b v=%b want s=%h c=%b v=%b",
                         n, a, b, sub, S_o, C_o, V_o, es, ec, ev);
            end
            checks++;
            if (lat !== W || busy_n !== W) begin
                errors++;
                $display("FAIL rand_%0d_latency got lat=%0d busy=%0d want %0d", n, lat, busy_n, W);
            end
            b2b = 1'($urandom);
            if (!b2b) begin
                @(negedge clk_i);
                checks++;
                if ({Done_o, Busy_o} !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_%0d_pulse got done=%b busy=%b want 0 0", n, Done_o, Busy_o);
                end
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni  = 1'b0;
        Start_i = 1'b0;
        Sub_i   = 1'b0;
        A_i     = '0;
        B_i     = '0;
        #1;
        test_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        test_add();
        test_back_to_back();
        test_sub();
        test_busy_protect();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
